// File: rtl/sorted_array_serializer.sv
// sorted_array_serializer: captures each completed sorted array on the rising
// edge of the engine's valid flag and streams it out one element per beat
// over valid/ready, element 0 first. One extra array can wait in a pending
// buffer while the current one drains. An array that arrives while both
// buffers are occupied is discarded, and the sticky overflow flag is set.
module sorted_array_serializer #(
    parameter int DATAWIDTH   = 8,
    parameter int ARRAYLENGTH = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATAWIDTH*ARRAYLENGTH-1:0] array_in,
    input  logic                             array_valid,
    output logic [DATAWIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             overflow
);

    localparam int              ARRAY_W  = DATAWIDTH * ARRAYLENGTH;
    localparam logic [7:0]      LAST_IDX = 8'(ARRAYLENGTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ARRAY_W-1:0]     active_q, active_d;
    logic [ARRAY_W-1:0]     pending_q, pending_d;
    logic                   pending_full_q, pending_full_d;
    logic [7:0]             idx_q, idx_d;
    logic                   valid_q;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [DATAWIDTH-1:0]   out_data_q, out_data_d;
    logic                   overflow_q, overflow_d;
    logic                   cap;
    logic                   stash;

    // Select element idx of a packed array (element 0 in the low bits).
    function automatic logic [DATAWIDTH-1:0] elem_at(input logic [ARRAY_W-1:0] arr,
                                                     input logic [7:0]         idx);
        elem_at = arr[int'(idx) * DATAWIDTH +: DATAWIDTH];
    endfunction

    // A held-high valid level captures exactly once: only its rising edge counts.
    assign cap = array_valid & ~valid_q;

    // Next-state logic for the stream controller and both array buffers.
    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        idx_d          = idx_q;
        out_valid_d    = out_valid_q;
        overflow_d     = overflow_q;
        stash          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap) begin
                    active_d    = array_in;
                    idx_d       = 8'd0;
                    out_valid_d = 1'b1;
                    state_d     = STREAM;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Final beat: chain the next array with no bubble if one exists.
                        if (pending_full_q) begin
                            active_d = pending_q;
                            idx_d    = 8'd0;
                            if (cap) begin
                                pending_d = array_in;
                            end else begin
                                pending_full_d = 1'b0;
                            end
                        end else if (cap) begin
                            active_d = array_in;
                            idx_d    = 8'd0;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 8'd1;
                        stash = cap;
                    end
                end else begin
                    stash = cap;
                end

                // A capture not consumed by the final beat goes to pending or is dropped.
                if (stash) begin
                    if (!pending_full_q) begin
                        pending_d      = array_in;
                        pending_full_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    overflow_d = overflow_q;
                end
            end
            default: begin
                state_d        = IDLE;
                out_valid_d    = 1'b0;
                pending_full_d = 1'b0;
            end
        endcase

        out_last_d = out_valid_d && (idx_d == LAST_IDX);
        out_data_d = elem_at(active_d, idx_d);
    end

    // State, buffers and registered outputs; reset abandons any array in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            idx_q          <= 8'd0;
            valid_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            idx_q          <= idx_d;
            valid_q        <= array_valid;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_data_q     <= out_data_d;
            overflow_q     <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = out_valid_q | pending_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sorted_array_serializer.sv
// Directed bench for sorted_array_serializer with DATAWIDTH=8, ARRAYLENGTH=4.
module tb_sorted_array_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] array_in;
    logic        array_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overflow;

    int          tests;
    int          fails;
    logic [7:0]  beats[$];
    logic [7:0]  exp_beats[$];
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [3:0]  ready_pat;

    sorted_array_serializer #(
        .DATAWIDTH  (8),
        .ARRAYLENGTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .array_in   (array_in),
        .array_valid(array_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_beats(input string tag);
        chk({tag, "_count"}, 32'(beats.size()), 32'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size(); i++) begin
            if (i < beats.size()) begin
                chk($sformatf("%s_beat%0d", tag, i), {24'd0, beats[i]}, {24'd0, exp_beats[i]});
            end
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        array_in    = 32'd0;
        array_valid = 1'b0;
        out_ready   = 1'b1;
        #1;
        // Reset values
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_overflow",  {31'd0, overflow},  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1) single pulse, always ready: 0C 09 05 01, last on 01
        array_in    = 32'h01_05_09_0C;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        chk("t1_v0", {31'd0, out_valid}, 32'd1);
        chk("t1_d0", {24'd0, out_data}, 32'h0C);
        chk("t1_l0", {31'd0, out_last}, 32'd0);
        tick();
        chk("t1_d1", {24'd0, out_data}, 32'h09);
        chk("t1_l1", {31'd0, out_last}, 32'd0);
        tick();
        chk("t1_d2", {24'd0, out_data}, 32'h05);
        tick();
        chk("t1_d3", {24'd0, out_data}, 32'h01);
        chk("t1_l3", {31'd0, out_last}, 32'd1);
        chk("t1_busy3", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_v_end", {31'd0, out_valid}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2) level held high 20 cycles: exactly one stream
        beats.delete();
        exp_beats = '{8'h0C, 8'h09, 8'h05, 8'h01};
        array_valid = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i == 19) array_valid = 1'b0;
            if (out_valid && out_ready) beats.push_back(out_data);
        end
        chk_beats("t2");
        chk("t2_overflow", {31'd0, overflow}, 32'd0);
        chk("t2_idle", {31'd0, out_valid}, 32'd0);

        // 3) out_ready toggling 1,0,0,1: stalls hold data, in order, no duplicates
        beats.delete();
        ready_pat   = 4'b1001;
        prev_stall  = 1'b0;
        prev_data   = 8'd0;
        array_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            array_valid = 1'b0;
            out_ready   = ready_pat[i % 4];
            if (prev_stall) chk($sformatf("t3_hold%0d", i), {24'd0, out_data}, {24'd0, prev_data});
            if (out_valid && out_ready) beats.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        chk_beats("t3");
        out_ready = 1'b1;
        tick();

        // 4) A active, B pending, C dropped; then drain with no bubble
        out_ready   = 1'b0;
        array_in    = 32'h04030201;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        tick();
        array_in    = 32'h08070605;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        chk("t4_ovf_after_b", {31'd0, overflow}, 32'd0);
        tick();
        array_in    = 32'h0C0B0A09;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        tick();
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        chk("t4_hold_data", {24'd0, out_data}, 32'h01);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        beats.delete();
        exp_beats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) beats.push_back(out_data);
            tick();
        end
        chk_beats("t4");
        chk("t4_idle", {31'd0, out_valid}, 32'd0);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // 5) capture on A's final beat, pending empty: chained, no gap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        array_in    = 32'h04030201;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        chk("t5_a0", {24'd0, out_data}, 32'h01);
        tick();
        tick();
        tick();
        chk("t5_a3", {24'd0, out_data}, 32'h04);
        chk("t5_a3_last", {31'd0, out_last}, 32'd1);
        array_in    = 32'h08070605;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        chk("t5_b0_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_b0", {24'd0, out_data}, 32'h05);
        chk("t5_b0_last", {31'd0, out_last}, 32'd0);
        tick();
        chk("t5_b1", {24'd0, out_data}, 32'h06);
        tick();
        tick();
        chk("t5_b3", {24'd0, out_data}, 32'h08);
        tick();
        chk("t5_idle", {31'd0, out_valid}, 32'd0);
        chk("t5_overflow", {31'd0, overflow}, 32'd0);

        // 6) async reset mid-stream at idx 2 with overflow set and pending full
        out_ready   = 1'b0;
        array_in    = 32'h04030201;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        tick();
        array_in    = 32'h08070605;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        tick();
        array_in    = 32'h0C0B0A09;
        array_valid = 1'b1;
        tick();
        array_valid = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        chk("t6_idx2_data", {24'd0, out_data}, 32'h03);
        chk("t6_pre_ovf", {31'd0, overflow}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_last",  {31'd0, out_last},  32'd0);
        chk("t6_rst_busy",  {31'd0, busy},      32'd0);
        chk("t6_rst_ovf",   {31'd0, overflow},  32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_resume", {31'd0, out_valid}, 32'd0);
        beats.delete();
        exp_beats   = '{8'h11, 8'h22, 8'h33, 8'h44};
        array_in    = 32'h44332211;
        array_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            array_valid = 1'b0;
            if (out_valid && out_ready) beats.push_back(out_data);
        end
        chk_beats("t6");
        chk("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
